// File: rtl/enigma_pkg.sv
// enigma_pkg: shared types, constants and keystroke classification for the enigma frontend
package enigma_pkg;
  localparam int LETTERS = 26;
  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_Q = 8'h3F;
  typedef logic [4:0] letter_t;
  typedef enum logic [1:0] {IDLE, STEP, SETTLE, HOLD} state_t;
  // {is_letter, index}; case-insensitive
  function automatic logic [5:0] classify(input logic [7:0] c);
    return (c >= ASCII_A && c < ASCII_A + 8'(LETTERS)) ? {1'b1, 5'(c - ASCII_A)} :
           (c >= ASCII_LA && c < ASCII_LA + 8'(LETTERS)) ? {1'b1, 5'(c - ASCII_LA)} : 6'd0;
  endfunction
endpackage

// File: rtl/enigma_step_ctr.sv
// enigma_step_ctr: one mod-26 rotor position with load, step and notch carry-out
module enigma_step_ctr
  import enigma_pkg::*;
#(
  parameter int NOTCH = 25
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    load,
  input  letter_t init,
  input  logic    step,
  output letter_t pos,
  output logic    carry
);
  assign carry = step && pos == letter_t'(NOTCH);
  always_ff @(posedge clk)
    if (!rst_n) pos <= '0;
    else if (load) pos <= (init >= 5'(LETTERS)) ? init - 5'(LETTERS) : init;
    else if (step) pos <= (pos == 5'(LETTERS - 1)) ? '0 : pos + 5'd1;
endmodule

// File: rtl/enigma_key_frontend.sv
// enigma_key_frontend: keystroke handshake, odometer rotor stepping and timed sampling of the rotor core
module enigma_key_frontend
  import enigma_pkg::*;
#(
  parameter int CORE_LAT      = 2,
  parameter int NOTCH0        = 25,
  parameter int NOTCH1        = 25,
  parameter int PASS_NONALPHA = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_pos,
  input  logic [4:0] pos_init_0,
  input  logic [4:0] pos_init_1,
  input  logic [4:0] pos_init_2,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_char,
  output logic [4:0] core_letter,
  output logic [4:0] core_pos0,
  output logic [4:0] core_pos1,
  output logic [4:0] core_pos2,
  input  logic [4:0] core_result,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_char,
  output logic       busy
);
  localparam logic [3:0] LAT_LAST = 4'(CORE_LAT - 1);
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [5:0] cls;
  logic accept, load_en, c0, c1, unused_carry, settle_done;
  assign cls = classify(in_char);
  assign accept = in_valid && in_ready;
  assign load_en = state == IDLE && load_pos;
  assign settle_done = state == SETTLE && cnt == LAT_LAST;
  enigma_step_ctr #(.NOTCH(NOTCH0)) u_ctr0 (
    .clk(clk), .rst_n(rst_n), .load(load_en), .init(pos_init_0),
    .step(state == STEP), .pos(core_pos0), .carry(c0)
  );
  enigma_step_ctr #(.NOTCH(NOTCH1)) u_ctr1 (
    .clk(clk), .rst_n(rst_n), .load(load_en), .init(pos_init_1),
    .step(c0), .pos(core_pos1), .carry(c1)
  );
  enigma_step_ctr #(.NOTCH(0)) u_ctr2 (
    .clk(clk), .rst_n(rst_n), .load(load_en), .init(pos_init_2),
    .step(c1), .pos(core_pos2), .carry(unused_carry)
  );
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = cls[5] ? STEP : (PASS_NONALPHA != 0) ? HOLD : IDLE;
      STEP:    state_nx = SETTLE;
      SETTLE:  if (settle_done) state_nx = HOLD;
      HOLD:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    in_ready = rst_n && state == IDLE && !load_pos;
    busy = state != IDLE;
  end
  // letter and positions only move at accept/STEP so the core inputs stay stable while settling
  always_ff @(posedge clk)
    if (!rst_n) begin
      core_letter <= '0;
      cnt <= '0;
      out_valid <= 1'b0;
      out_char <= 8'h00;
    end else begin
      if (accept && cls[5]) core_letter <= cls[4:0];
      cnt <= (state == SETTLE) ? cnt + 4'd1 : 4'd0;
      if (accept && !cls[5] && PASS_NONALPHA != 0) begin
        out_char <= in_char;
        out_valid <= 1'b1;
      end else if (settle_done) begin
        out_char <= (core_result > 5'(LETTERS - 1)) ? ASCII_Q : ASCII_A + 8'(core_result);
        out_valid <= 1'b1;
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_enigma_key_frontend.sv
// tb_enigma_key_frontend: directed checks of stepping, latency, pass-through/drop, backpressure and reset
module tb_enigma_key_frontend;
  logic clk = 0, rst_n = 0, load_pos = 0, in_valid = 0, in_valid_b = 0, out_ready = 0, force_bad = 0;
  logic [4:0] pos_init_0 = 0, pos_init_1 = 0, pos_init_2 = 0;
  logic [7:0] in_char = 0;
  logic in_ready, out_valid, busy, in_ready_b, out_valid_b, busy_b;
  logic [4:0] core_letter, core_pos0, core_pos1, core_pos2, core_result;
  logic [4:0] core_letter_b, pos_b0, pos_b1, pos_b2, core_result_b;
  logic [7:0] out_char, out_char_b;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  // core stub: idx -> (idx + 4) mod 26, optionally forced out of range
  assign core_result = force_bad ? 5'd30 : 5'((int'(core_letter) + 4) % 26);
  assign core_result_b = 5'((int'(core_letter_b) + 4) % 26);
  enigma_key_frontend #(.CORE_LAT(2), .NOTCH0(25), .NOTCH1(25), .PASS_NONALPHA(1)) dut (
    .clk(clk), .rst_n(rst_n), .load_pos(load_pos),
    .pos_init_0(pos_init_0), .pos_init_1(pos_init_1), .pos_init_2(pos_init_2),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .core_letter(core_letter), .core_pos0(core_pos0), .core_pos1(core_pos1), .core_pos2(core_pos2),
    .core_result(core_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_char(out_char), .busy(busy)
  );
  enigma_key_frontend #(.CORE_LAT(2), .NOTCH0(25), .NOTCH1(25), .PASS_NONALPHA(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .load_pos(load_pos),
    .pos_init_0(pos_init_0), .pos_init_1(pos_init_1), .pos_init_2(pos_init_2),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_char(in_char),
    .core_letter(core_letter_b), .core_pos0(pos_b0), .core_pos1(pos_b1), .core_pos2(pos_b2),
    .core_result(core_result_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_char(out_char_b), .busy(busy_b)
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_pos(input string tag, input int a, input int b, input int c);
    check({tag, "_pos0"}, int'(core_pos0), a);
    check({tag, "_pos1"}, int'(core_pos1), b);
    check({tag, "_pos2"}, int'(core_pos2), c);
  endtask
  task automatic do_load(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    @(negedge clk);
    load_pos = 1; pos_init_0 = a; pos_init_1 = b; pos_init_2 = c;
    #1 check("in_ready_during_load", int'(in_ready), 0);
    @(negedge clk);
    load_pos = 0;
  endtask
  task automatic send(input logic [7:0] ch, output int lat);
    @(negedge clk);
    check("in_ready_idle", int'(in_ready), 1);
    in_char = ch; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic drain;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("drained_valid", int'(out_valid), 0);
    check("drained_busy", int'(busy), 0);
  endtask
  task automatic send_letter(input logic [7:0] ch, input int idx, input int exp, input int a, input int b, input int c);
    int lat;
    send(ch, lat);
    check("letter_latency", lat, 4);
    check("letter_out_char", int'(out_char), exp);
    check("letter_core_letter", int'(core_letter), idx);
    chk_pos("letter", a, b, c);
    drain;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat;
    logic stale;
    repeat (2) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_char", int'(out_char), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_core_letter", int'(core_letter), 0);
    chk_pos("rst", 0, 0, 0);
    rst_n = 1;
    do_load(0, 0, 0);
    send_letter(8'h41, 0, 8'h45, 1, 0, 0);
    do_load(25, 3, 7);
    send_letter(8'h62, 1, 8'h46, 0, 4, 7);
    do_load(25, 25, 25);
    send_letter(8'h7A, 25, 8'h44, 0, 0, 0);
    do_load(24, 25, 0);
    send_letter(8'h43, 2, 8'h47, 25, 25, 0);
    send_letter(8'h44, 3, 8'h48, 0, 0, 1);
    do_load(30, 26, 31);
    chk_pos("load_mod", 4, 0, 5);
    send(8'h20, lat);
    check("pass_latency", lat, 1);
    check("pass_out_char", int'(out_char), 8'h20);
    chk_pos("pass", 4, 0, 5);
    drain;
    @(negedge clk);
    check("drop_in_ready", int'(in_ready_b), 1);
    in_char = 8'h20; in_valid_b = 1;
    @(negedge clk);
    in_valid_b = 0;
    stale = 0;
    repeat (5) begin
      stale |= out_valid_b | !in_ready_b;
      @(negedge clk);
    end
    check("drop_no_output", int'(stale), 0);
    check("drop_pos0", int'(pos_b0), 4);
    send(8'h41, lat);
    check("bp_latency", lat, 4);
    repeat (10) @(negedge clk);
    check("bp_out_char", int'(out_char), 8'h45);
    check("bp_out_valid", int'(out_valid), 1);
    check("bp_in_ready", int'(in_ready), 0);
    check("bp_busy", int'(busy), 1);
    load_pos = 1; pos_init_0 = 0; pos_init_1 = 0; pos_init_2 = 0;
    @(negedge clk);
    load_pos = 0;
    chk_pos("bp_load_ignored", 5, 0, 5);
    check("bp_still_valid", int'(out_valid), 1);
    drain;
    force_bad = 1;
    send(8'h45, lat);
    check("bad_out_char", int'(out_char), 8'h3F);
    drain;
    force_bad = 0;
    chk_pos("bad", 6, 0, 5);
    @(negedge clk);
    in_char = 8'h41; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    check("settle_busy", int'(busy), 1);
    rst_n = 0;
    @(negedge clk);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_in_ready", int'(in_ready), 0);
    chk_pos("mid_rst", 0, 0, 0);
    rst_n = 1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      stale |= out_valid;
    end
    check("mid_rst_no_stale", int'(stale), 0);
    check("mid_rst_ready_after", int'(in_ready), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
